// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: datapath widths, func codes and the
// reservation-station entry layout with its CDB snoop helper.
package tomasulo_pkg;

  localparam int DW = 8;
  localparam int TW = 3;
  localparam int FW = 4;
  localparam int RW = 4;

  typedef enum logic [FW-1:0] {
    FN_ADD = 4'b0000,
    FN_SUB = 4'b0001,
    FN_MUL = 4'b0010,
    FN_DIV = 4'b0011,
    FN_LD  = 4'b0100,
    FN_ST  = 4'b0101
  } func_e;

  typedef struct packed {
    logic          rdy;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } rs_opnd_t;

  typedef struct packed {
    logic          valid;
    logic [FW-1:0] func;
    logic [RW-1:0] rd;
    logic [TW-1:0] rob;
    rs_opnd_t      rs1;
    rs_opnd_t      rs2;
  } rs_entry_t;

  // A waiting operand whose producer tag is on the CDB takes the broadcast value.
  function automatic rs_opnd_t snoop_opnd(input rs_opnd_t o, input logic cv,
                                          input logic [TW-1:0] ct, input logic [DW-1:0] cd);
    rs_opnd_t r;
    r = o;
    if (!o.rdy && cv && (o.tag == ct)) begin
      r.rdy  = 1'b1;
      r.data = cd;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_oldest_pick.sv
// Oldest-first selector: lowest set bit of the ready vector wins, reported
// both as a one-hot grant and as a binary index.
module rs_oldest_pick #(
  parameter  int DEPTH = 4,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] grant_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  // seen[i] is set when any slot below i is requesting.
  logic [DEPTH:0] seen;

  assign seen[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_chain
      assign seen[gi+1]  = seen[gi] | req_i[gi];
      assign grant_o[gi] = req_i[gi] & ~seen[gi];
    end
  endgenerate

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant_o[i]) idx_o = IW'(i);
    end
  end

  assign any_o = seen[DEPTH];

endmodule

// File: rtl/reservation_station.sv
// Collapsing reservation station: slot 0 is oldest, operands wait on ROB tags
// resolved by CDB snooping, and the oldest fully-ready entry is offered to exec.
module reservation_station
  import tomasulo_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [FW-1:0] iss_func,
  input  logic [RW-1:0] iss_rd,
  input  logic [TW-1:0] iss_rob,
  input  logic          iss_rs1_rdy,
  input  logic [DW-1:0] iss_rs1_data,
  input  logic [TW-1:0] iss_rs1_tag,
  input  logic          iss_rs2_rdy,
  input  logic [DW-1:0] iss_rs2_data,
  input  logic [TW-1:0] iss_rs2_tag,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_tag,
  input  logic [DW-1:0] cdb_data,
  output logic          disp_valid,
  input  logic          disp_ready,
  output logic [FW-1:0] disp_func,
  output logic [DW-1:0] disp_rs1_data,
  output logic [DW-1:0] disp_rs2_data,
  output logic [TW-1:0] disp_rob_ind,
  output logic [RW-1:0] disp_rd,
  output logic [CW-1:0] count
);

  rs_entry_t        ent_q [DEPTH];
  rs_entry_t        ent_d [DEPTH];
  rs_entry_t        snp   [DEPTH];
  rs_entry_t        shf   [DEPTH];
  rs_entry_t        new_ent;
  logic [CW-1:0]    count_q, count_d, wr_slot;
  logic [DEPTH-1:0] rdy_vec, grant;
  logic [IW-1:0]    pick_idx;
  logic             any_rdy, issue_acc, disp_fire;

  // Readiness comes from registered state only, so a CDB wake-up dispatches next cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rdy
      assign rdy_vec[gi] = ent_q[gi].valid & ent_q[gi].rs1.rdy & ent_q[gi].rs2.rdy;
    end
  endgenerate

  rs_oldest_pick #(.DEPTH(DEPTH)) u_pick (
    .req_i   (rdy_vec),
    .grant_o (grant),
    .idx_o   (pick_idx),
    .any_o   (any_rdy)
  );

  assign iss_ready  = (count_q < CW'(DEPTH));
  assign issue_acc  = iss_valid & iss_ready;
  assign disp_valid = any_rdy;
  assign disp_fire  = any_rdy & disp_ready;
  assign count      = count_q;
  assign wr_slot    = disp_fire ? (count_q - CW'(1)) : count_q;

  always_comb begin
    disp_func     = '0;
    disp_rs1_data = '0;
    disp_rs2_data = '0;
    disp_rob_ind  = '0;
    disp_rd       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        disp_func     = ent_q[i].func;
        disp_rs1_data = ent_q[i].rs1.data;
        disp_rs2_data = ent_q[i].rs2.data;
        disp_rob_ind  = ent_q[i].rob;
        disp_rd       = ent_q[i].rd;
      end
    end
  end

  // Snooped view of every slot, and the same view shifted down by one for collapse.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      snp[i] = ent_q[i];
      if (ent_q[i].valid) begin
        snp[i].rs1 = snoop_opnd(ent_q[i].rs1, cdb_valid, cdb_tag, cdb_data);
        snp[i].rs2 = snoop_opnd(ent_q[i].rs2, cdb_valid, cdb_tag, cdb_data);
      end
    end
    for (int i = 0; i < DEPTH - 1; i++) shf[i] = snp[i+1];
    shf[DEPTH-1] = '0;
  end

  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.func     = iss_func;
    new_ent.rd       = iss_rd;
    new_ent.rob      = iss_rob;
    new_ent.rs1.rdy  = iss_rs1_rdy;
    new_ent.rs1.data = iss_rs1_rdy ? iss_rs1_data : '0;
    new_ent.rs1.tag  = iss_rs1_tag;
    new_ent.rs2.rdy  = iss_rs2_rdy;
    new_ent.rs2.data = iss_rs2_rdy ? iss_rs2_data : '0;
    new_ent.rs2.tag  = iss_rs2_tag;
    new_ent.rs1      = snoop_opnd(new_ent.rs1, cdb_valid, cdb_tag, cdb_data);
    new_ent.rs2      = snoop_opnd(new_ent.rs2, cdb_valid, cdb_tag, cdb_data);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (disp_fire && (IW'(i) >= pick_idx)) ? shf[i] : snp[i];
      if (issue_acc && (wr_slot == CW'(i))) ent_d[i] = new_ent;
      if (flush) ent_d[i] = '0;
    end
    count_d = count_q;
    if (flush) count_d = '0;
    else if (issue_acc && !disp_fire) count_d = count_q + CW'(1);
    else if (!issue_acc && disp_fire) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed and randomized checks of reservation_station against a queue-based
// reference model of the oldest-ready-first operand buffer.
module tb_reservation_station;
  import tomasulo_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk1 = 1'b0;
  logic          rst_n, flush, iss_valid, iss_ready;
  logic [FW-1:0] iss_func;
  logic [RW-1:0] iss_rd;
  logic [TW-1:0] iss_rob, iss_rs1_tag, iss_rs2_tag, cdb_tag, disp_rob_ind;
  logic          iss_rs1_rdy, iss_rs2_rdy, cdb_valid, disp_valid, disp_ready;
  logic [DW-1:0] iss_rs1_data, iss_rs2_data, cdb_data, disp_rs1_data, disp_rs2_data;
  logic [FW-1:0] disp_func;
  logic [RW-1:0] disp_rd;
  logic [CW-1:0] count;

  always #5 clk1 = ~clk1;

  reservation_station #(.DEPTH(DEPTH)) dut (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_func(iss_func), .iss_rd(iss_rd),
    .iss_rob(iss_rob), .iss_rs1_rdy(iss_rs1_rdy), .iss_rs1_data(iss_rs1_data),
    .iss_rs1_tag(iss_rs1_tag), .iss_rs2_rdy(iss_rs2_rdy), .iss_rs2_data(iss_rs2_data),
    .iss_rs2_tag(iss_rs2_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_func(disp_func),
    .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
    .disp_rob_ind(disp_rob_ind), .disp_rd(disp_rd), .count(count)
  );

  typedef struct {
    logic [FW-1:0] func;
    logic [RW-1:0] rd;
    logic [TW-1:0] rob;
    logic          r1rdy;
    logic [DW-1:0] r1d;
    logic [TW-1:0] r1t;
    logic          r2rdy;
    logic [DW-1:0] r2d;
    logic [TW-1:0] r2t;
  } op_t;

  op_t mq[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_iss(input logic v, input logic [FW-1:0] f, input logic [RW-1:0] rd,
                         input logic [TW-1:0] rob,
                         input logic r1, input logic [DW-1:0] d1, input logic [TW-1:0] t1,
                         input logic r2, input logic [DW-1:0] d2, input logic [TW-1:0] t2);
    iss_valid = v; iss_func = f; iss_rd = rd; iss_rob = rob;
    iss_rs1_rdy = r1; iss_rs1_data = d1; iss_rs1_tag = t1;
    iss_rs2_rdy = r2; iss_rs2_data = d2; iss_rs2_tag = t2;
  endtask

  // Compare outputs against the model, clock once, then advance the model.
  task automatic step();
    int  sel;
    op_t n;
    logic f_flush, fire, acc, cv;
    logic [TW-1:0] ct;
    logic [DW-1:0] cd;
    sel = -1;
    foreach (mq[k]) if (sel < 0 && mq[k].r1rdy && mq[k].r2rdy) sel = k;
    chk("count", 32'(count), 32'(mq.size()));
    chk("iss_ready", 32'(iss_ready), 32'(mq.size() < DEPTH));
    chk("disp_valid", 32'(disp_valid), 32'(sel >= 0));
    if (sel >= 0) begin
      chk("disp_func", 32'(disp_func), 32'(mq[sel].func));
      chk("disp_rs1", 32'(disp_rs1_data), 32'(mq[sel].r1d));
      chk("disp_rs2", 32'(disp_rs2_data), 32'(mq[sel].r2d));
      chk("disp_rob", 32'(disp_rob_ind), 32'(mq[sel].rob));
      chk("disp_rd", 32'(disp_rd), 32'(mq[sel].rd));
    end else begin
      chk("disp_idle_data", 32'({disp_func, disp_rs1_data, disp_rs2_data}) |
          32'({disp_rob_ind, disp_rd}), 32'(0));
    end
    f_flush = flush;
    fire    = (sel >= 0) && disp_ready;
    acc     = iss_valid && (mq.size() < DEPTH);
    cv = cdb_valid; ct = cdb_tag; cd = cdb_data;
    n.func = iss_func; n.rd = iss_rd; n.rob = iss_rob;
    n.r1rdy = iss_rs1_rdy; n.r1d = iss_rs1_rdy ? iss_rs1_data : '0; n.r1t = iss_rs1_tag;
    n.r2rdy = iss_rs2_rdy; n.r2d = iss_rs2_rdy ? iss_rs2_data : '0; n.r2t = iss_rs2_tag;
    @(posedge clk1);
    #1;
    if (f_flush) begin
      mq.delete();
    end else begin
      foreach (mq[k]) begin
        if (cv && !mq[k].r1rdy && mq[k].r1t == ct) begin mq[k].r1rdy = 1'b1; mq[k].r1d = cd; end
        if (cv && !mq[k].r2rdy && mq[k].r2t == ct) begin mq[k].r2rdy = 1'b1; mq[k].r2d = cd; end
      end
      if (fire) mq.delete(sel);
      if (acc) begin
        if (cv && !n.r1rdy && n.r1t == ct) begin n.r1rdy = 1'b1; n.r1d = cd; end
        if (cv && !n.r2rdy && n.r2t == ct) begin n.r2rdy = 1'b1; n.r2d = cd; end
        mq.push_back(n);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; disp_ready = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    set_iss(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_iss_ready", 32'(iss_ready), 32'(1));
    chk("rst_disp_valid", 32'(disp_valid), 32'(0));
    #11 rst_n = 1'b1;
    @(posedge clk1); #1;
    repeat (5) step();

    // Ready issue straight through to dispatch
    disp_ready = 1'b1;
    set_iss(1'b1, FN_ADD, 4'd1, 3'd2, 1'b1, 8'h05, 3'd0, 1'b1, 8'h03, 3'd0);
    step();
    iss_valid = 1'b0;
    chk("add_valid", 32'(disp_valid), 32'(1));
    chk("add_rs1", 32'(disp_rs1_data), 32'h05);
    chk("add_rs2", 32'(disp_rs2_data), 32'h03);
    chk("add_rob", 32'(disp_rob_ind), 32'd2);
    chk("add_count", 32'(count), 32'd1);
    step();
    chk("add_drained", 32'(count), 32'd0);

    // CDB wake-up: dispatchable the cycle after the broadcast
    set_iss(1'b1, FN_SUB, 4'd2, 3'd3, 1'b0, 8'h00, 3'd4, 1'b1, 8'h10, 3'd0);
    step();
    iss_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 8'h22;
    chk("wake_same_cycle", 32'(disp_valid), 32'(0));
    step();
    cdb_valid = 1'b0;
    chk("wake_valid", 32'(disp_valid), 32'(1));
    chk("wake_rs1", 32'(disp_rs1_data), 32'h22);
    chk("wake_rs2", 32'(disp_rs2_data), 32'h10);
    step();

    // Issue/CDB bypass
    set_iss(1'b1, FN_MUL, 4'd3, 3'd5, 1'b1, 8'h11, 3'd0, 1'b0, 8'h00, 3'd1);
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 8'h7F;
    step();
    iss_valid = 1'b0; cdb_valid = 1'b0;
    chk("byp_valid", 32'(disp_valid), 32'(1));
    chk("byp_rs2", 32'(disp_rs2_data), 32'h7F);
    step();

    // Fill with slots 1 and 3 ready, then drain oldest-ready first
    disp_ready = 1'b0;
    set_iss(1'b1, FN_DIV, 4'd4, 3'd0, 1'b0, 8'h00, 3'd5, 1'b1, 8'h01, 3'd0); step();
    set_iss(1'b1, FN_LD,  4'd5, 3'd1, 1'b1, 8'h21, 3'd0, 1'b1, 8'h22, 3'd0); step();
    set_iss(1'b1, FN_ST,  4'd6, 3'd2, 1'b1, 8'h31, 3'd0, 1'b0, 8'h00, 3'd6); step();
    set_iss(1'b1, FN_ADD, 4'd7, 3'd3, 1'b1, 8'h41, 3'd0, 1'b1, 8'h42, 3'd0); step();
    chk("full_iss_ready", 32'(iss_ready), 32'(0));
    chk("full_count", 32'(count), 32'd4);
    chk("full_pick", 32'(disp_rob_ind), 32'd1);
    set_iss(1'b1, FN_SUB, 4'd8, 3'd7, 1'b1, 8'h55, 3'd0, 1'b1, 8'h66, 3'd0);
    step();
    chk("full_hold_rob", 32'(disp_rob_ind), 32'd1);
    chk("full_drop", 32'(count), 32'd4);
    iss_valid = 1'b0; disp_ready = 1'b1;
    step();
    chk("order_count3", 32'(count), 32'd3);
    chk("order_second", 32'(disp_rob_ind), 32'd3);
    step();
    chk("order_count2", 32'(count), 32'd2);
    chk("order_none", 32'(disp_valid), 32'(0));
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 8'hA5; step();
    cdb_tag = 3'd6; cdb_data = 8'hB6; step();
    cdb_valid = 1'b0;
    repeat (3) step();

    // Flush beats same-cycle issue and dispatch
    disp_ready = 1'b0;
    set_iss(1'b1, FN_LD, 4'd1, 3'd1, 1'b1, 8'h01, 3'd0, 1'b1, 8'h02, 3'd0); step();
    set_iss(1'b1, FN_ST, 4'd2, 3'd2, 1'b1, 8'h03, 3'd0, 1'b1, 8'h04, 3'd0); step();
    set_iss(1'b1, FN_MUL, 4'd3, 3'd3, 1'b1, 8'h05, 3'd0, 1'b1, 8'h06, 3'd0);
    disp_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; iss_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(disp_valid), 32'(0));
    step();

    // Randomized traffic with occasional flush and asynchronous reset
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 127) == 0) begin
        rst_n = 1'b0;
        #2;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(disp_valid), 32'(0));
        mq.delete();
        rst_n = 1'b1;
      end
      set_iss(1'($urandom_range(0, 1)), FN_ADD + 4'($urandom_range(0, 5)), 4'($urandom),
              3'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom),
              1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom));
      cdb_valid  = 1'($urandom_range(0, 1));
      cdb_tag    = 3'($urandom);
      cdb_data   = 8'($urandom);
      disp_ready = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
